ram32x4: RTL and testbench
==========================

Name: ram32x4

Overview:
- Single-port synchronous 32-word x 4-bit RAM with a registered read port and a write enable.
- Wrapped by the lab-level `ram` block; serves as a small scratch memory driven by switch/key inputs.
- Flop-based storage, so reset can clear the entire contents.

Parameters:
- ADDR_W, 5, address width; depth is 2**ADDR_W = 32 words
- DATA_W, 4, word width in bits

Ports:
- clock    input   1       rising-edge clock for all state
- reset_n  input   1       asynchronous, active-low reset
- address  input   ADDR_W  word address for both read and write
- data     input   DATA_W  write data
- wren     input   1       write enable; 1 = write data to address on this rising edge
- q        output  DATA_W  registered read data

Behaviour:
- Reset:
  - reset_n low asynchronously clears all 32 words to 4'b0000 and q to 4'b0000.
  - Reset is held while low; release takes effect at the next rising edge.
  - Reset asserted mid-write aborts that write; the word stays 0.
- Write: on a rising edge with reset_n high and wren=1, mem[address] <= data.
- Read:
  - On every rising edge with reset_n high, q <= mem[address], regardless of wren.
  - Read latency is one cycle: q is valid after the edge at which address was sampled.
- Read-during-write, same edge, same address: q returns the NEW data (write-through). q equals data one cycle after the write edge.
- Address decode:
  - Full ADDR_W bits are used; there is no out-of-range case.
  - Upper bits of wider drivers are truncated by the instantiator. A 5'h2A literal is 0x0A and 5'h42 is 0x02.
- q holds its value only via re-reads: it updates every cycle and has no read enable.
- X handling: none required; all state is defined after reset.

Optional Feature:
- Macro RAM32X4_OUTREG_EN.
- Defined:
  - Adds a second pipeline register after q; read latency becomes 2 cycles.
  - Read-during-write still returns the new data, now 2 cycles later.
  - The extra register also resets to 0 asynchronously.
- Undefined: single-register path as in Behaviour, latency 1.

Decomposition:
- Package ram32x4_pkg:
  - localparams ADDR_W=5, DATA_W=4, DEPTH=32
  - typedefs addr_t (logic [ADDR_W-1:0]) and word_t (logic [DATA_W-1:0])
  - constant WORD_RESET = '0
- One natural sub-module, ram32x4_array:
  - the 32-entry flop storage with async clear and write port
  - exposes a combinational read of mem[address]
- Top ram32x4 adds:
  - the write-through bypass mux
  - the q register(s)

Test Plan:
- Reset check: hold reset_n=0 for 2 cycles, release, then read every address 0..31 -> q=4'b0000 one cycle after each address is presented.
- Write/read pair:
  - write 4'b1010 @0x0A, then 4'b0101 @0x02
  - read 0x0A -> q=4'b1010 after 1 edge
  - read 0x02 -> q=4'b0101 after the next edge
- Write-through: wren=1, address=0x1F, data=4'b1100 -> q=4'b1100 one edge later; with RAM32X4_OUTREG_EN defined, 2 edges later.
- Fill/readback: write word value (addr ^ 4'hF) to all 32 addresses, then read back sequentially -> each q matches, with the 1-cycle offset.
- Async reset mid-operation:
  - after the fill, pulse reset_n low between edges -> q goes 0 immediately without waiting for a clock
  - subsequent reads of 0x05 and 0x1F -> 0
- Write-disable: wren=0 with data=4'b1111 @0x03 (previously 4'b0110) -> read 0x03 returns 4'b0110.

Source files
------------

// File: rtl/ram32x4_pkg.sv
// Shared widths, types and reset value for the 32x4 scratch RAM.
// Optional second output register is selected with RAM32X4_OUTREG_EN.
package ram32x4_pkg;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 4;
  localparam int unsigned DEPTH  = 2 ** ADDR_W;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] word_t;

  localparam word_t WORD_RESET = '0;

endpackage : ram32x4_pkg

// File: rtl/ram32x4_array.sv
// Flop-based 32-word storage with async clear, one write port and a
// combinational read of the addressed word.
module ram32x4_array
  import ram32x4_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  wr_en,
  input  addr_t addr,
  input  word_t wr_data,
  output word_t rd_data_c
);

  word_t [DEPTH-1:0] mem_q;
  word_t [DEPTH-1:0] mem_d;

  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[addr] = wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= {DEPTH{WORD_RESET}};
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd_data_c = mem_q[addr];

endmodule : ram32x4_array

// File: rtl/ram32x4.sv
// Single-port 32x4 RAM: registered read with write-through on same-address
// writes. RAM32X4_OUTREG_EN adds a second output register (latency 2).
module ram32x4
  import ram32x4_pkg::*;
(
  input  logic  clock,
  input  logic  reset_n,
  input  addr_t address,
  input  word_t data,
  input  logic  wren,
  output word_t q
);

  word_t rd_data_c;
  word_t rd_word_c;
  word_t q_q;
  word_t q_d;

  ram32x4_array u_array (
    .clk       (clock),
    .rst_n     (reset_n),
    .wr_en     (wren),
    .addr      (address),
    .wr_data   (data),
    .rd_data_c (rd_data_c)
  );

  // A write always targets the read address, so the bypass needs no compare.
  assign rd_word_c = wren ? data : rd_data_c;

  always_comb begin
    q_d = rd_word_c;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      q_q <= WORD_RESET;
    end else begin
      q_q <= q_d;
    end
  end

`ifdef RAM32X4_OUTREG_EN
  word_t q2_q;
  word_t q2_d;

  always_comb begin
    q2_d = q_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      q2_q <= WORD_RESET;
    end else begin
      q2_q <= q2_d;
    end
  end

  assign q = q2_q;
`else
  assign q = q_q;
`endif

endmodule : ram32x4

// File: tb/tb_ram32x4.sv
// Directed, table-driven bench for ram32x4; expected values are the
// single-register results, delayed one extra vector when RAM32X4_OUTREG_EN.
module tb_ram32x4;

  logic       clock;
  logic       reset_n;
  logic [4:0] address;
  logic [3:0] data;
  logic       wren;
  logic [3:0] q;

  int n_vec;
  int n_err;
  logic [3:0] pend;

  typedef struct {
    logic       wren;
    logic [4:0] addr;
    logic [3:0] data;
    logic [3:0] exp;
  } vec_t;

  localparam int NVEC = 12;
  vec_t tbl [NVEC];

  ram32x4 dut (
    .clock   (clock),
    .reset_n (reset_n),
    .address (address),
    .data    (data),
    .wren    (wren),
    .q       (q)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [3:0] req);
    n_vec++;
    if (q !== req) begin
      n_err++;
      $display("FAIL %s: q=%b required=%b at %0t", name, q, req, $time);
    end
  endtask

  // Drive one cycle, then compare q #1 after the edge.
  task automatic apply(input string name, input logic w, input logic [4:0] a,
                       input logic [3:0] d, input logic [3:0] exp);
    logic [3:0] req;
    wren    = w;
    address = a;
    data    = d;
    @(posedge clock);
    #1;
`ifdef RAM32X4_OUTREG_EN
    req  = pend;
    pend = exp;
`else
    req  = exp;
`endif
    check(name, req);
  endtask

  initial begin
    logic [7:0] wide;
    n_vec   = 0;
    n_err   = 0;
    pend    = 4'b0000;
    wren    = 1'b0;
    address = 5'h00;
    data    = 4'h0;

    tbl[0]  = '{1'b1, 5'h0A, 4'b1010, 4'b1010};
    tbl[1]  = '{1'b1, 5'h02, 4'b0101, 4'b0101};
    tbl[2]  = '{1'b0, 5'h0A, 4'b0000, 4'b1010};
    tbl[3]  = '{1'b0, 5'h02, 4'b1111, 4'b0101};
    tbl[4]  = '{1'b1, 5'h1F, 4'b1100, 4'b1100};
    tbl[5]  = '{1'b0, 5'h1F, 4'b0000, 4'b1100};
    tbl[6]  = '{1'b1, 5'h03, 4'b0110, 4'b0110};
    tbl[7]  = '{1'b0, 5'h03, 4'b1111, 4'b0110};
    tbl[8]  = '{1'b0, 5'h03, 4'b0000, 4'b0110};
    tbl[9]  = '{1'b0, 5'h00, 4'b0000, 4'b0000};
    tbl[10] = '{1'b0, 5'h1E, 4'b0000, 4'b0000};
    tbl[11] = '{1'b0, 5'h0A, 4'b0000, 4'b1010};

    // Reset held for two edges.
    reset_n = 1'b0;
    #1;
    check("reset_async", 4'b0000);
    @(posedge clock);
    @(posedge clock);
    #1;
    check("reset_held", 4'b0000);
    @(negedge clock);
    reset_n = 1'b1;
    #1;

    for (int a = 0; a < 32; a++) begin
      apply("reset_read", 1'b0, 5'(a), 4'h0, 4'b0000);
    end

    for (int i = 0; i < NVEC; i++) begin
      apply("table", tbl[i].wren, tbl[i].addr, tbl[i].data, tbl[i].exp);
    end

    // Wider drivers truncated to 5 bits: 0x2A -> 0x0A, 0x42 -> 0x02.
    wide = 8'h2A;
    apply("trunc_2a", 1'b0, 5'(wide), 4'h0, 4'b1010);
    wide = 8'h42;
    apply("trunc_42", 1'b0, 5'(wide), 4'h0, 4'b0101);

    for (int a = 0; a < 32; a++) begin
      apply("fill_wt", 1'b1, 5'(a), 4'(a) ^ 4'hF, 4'(a) ^ 4'hF);
    end
    for (int a = 0; a < 32; a++) begin
      apply("readback", 1'b0, 5'(a), 4'h0, 4'(a) ^ 4'hF);
    end
    apply("pre_rst_05", 1'b0, 5'h05, 4'h0, 4'hA);
    apply("pre_rst_05b", 1'b0, 5'h05, 4'h0, 4'hA);

    // Reset pulse between edges clears q with no clock.
    #2;
    reset_n = 1'b0;
    #1;
    check("midop_reset", 4'b0000);
    #1;
    reset_n = 1'b1;
    pend    = 4'b0000;
    apply("post_rst_05", 1'b0, 5'h05, 4'h0, 4'b0000);
    apply("post_rst_1f", 1'b0, 5'h1F, 4'h0, 4'b0000);
    apply("post_rst_1fb", 1'b0, 5'h1F, 4'h0, 4'b0000);

    // Write-disable after reset: 0x03 keeps 0110.
    apply("wd_write", 1'b1, 5'h03, 4'b0110, 4'b0110);
    apply("wd_nowrite", 1'b0, 5'h03, 4'b1111, 4'b0110);
    apply("wd_read", 1'b0, 5'h03, 4'b0000, 4'b0110);
    apply("wd_read_b", 1'b0, 5'h03, 4'b0000, 4'b0110);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_ram32x4
